// File: rtl/sys_array_pkg.sv
// Shared types and sizing helpers for the systolic-array feeder and its cells.
package sys_array_pkg;

    localparam int CELL_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN
    } state_t;

    // One counter serves both the weight beat count and the drain countdown.
    function automatic int cnt_width(input int beats, input int drain);
        int m;
        m = (beats > drain) ? beats : drain;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sys_array_feeder_if.sv
// Handshake and array-side bus of the systolic-array feeder.
interface sys_array_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_H    = 4,
    parameter int ARRAY_W    = 4
);
    logic                          w_valid;
    logic                          w_ready;
    logic [ARRAY_W*DATA_WIDTH-1:0] w_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [ARRAY_H*DATA_WIDTH-1:0] in_data;
    logic                          in_last;
    logic                          weight_load;
    logic [ARRAY_W*DATA_WIDTH-1:0] weight_data;
    logic [ARRAY_H*DATA_WIDTH-1:0] array_in;
    logic [ARRAY_H-1:0]            array_in_valid;
    logic                          busy;
    logic                          done;

    modport slave (
        input  w_valid, w_data, in_valid, in_data, in_last,
        output w_ready, in_ready, weight_load, weight_data,
               array_in, array_in_valid, busy, done
    );

    modport master (
        output w_valid, w_data, in_valid, in_data, in_last,
        input  w_ready, in_ready, weight_load, weight_data,
               array_in, array_in_valid, busy, done
    );

endinterface

// File: rtl/sys_array_skew_line.sv
// One row's {valid, data} delay chain; DEPTH registers between input and output.
module sys_array_skew_line #(
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage[0] <= '0;
        end else begin
            stage[0] <= {in_valid, in_data};
        end
    end

    for (genvar i = 1; i < DEPTH; i++) begin : g_stage
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stage[i] <= '0;
            end else begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign {out_valid, out_data} = stage[DEPTH-1];

endmodule

// File: rtl/sys_array_feeder.sv
// Weight-load / skewed-activation feeder for the weight-stationary systolic array.
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int DATA_WIDTH   = CELL_DATA_WIDTH,
    parameter int ARRAY_H      = 4,
    parameter int ARRAY_W      = 4,
    parameter int DRAIN_CYCLES = ARRAY_H - 1 + ARRAY_W
) (
    input  logic               clk,
    input  logic               reset_n,
    sys_array_feeder_if.slave  bus
);

    localparam int CW = cnt_width(ARRAY_H, DRAIN_CYCLES);
    localparam logic [CW-1:0] ONE        = CW'(1);
    localparam logic [CW-1:0] LAST_BEAT  = CW'(ARRAY_H - 1);
    localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN_CYCLES);

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            w_acc, in_acc;
    logic            done_n;

    logic [DATA_WIDTH-1:0] row_d [ARRAY_H];
    logic [DATA_WIDTH-1:0] row_q [ARRAY_H];
    logic [ARRAY_H-1:0]    row_v;

    assign bus.w_ready  = (state == IDLE) || (state == LOAD_W);
    assign bus.in_ready = (state == STREAM);
    assign w_acc        = bus.w_valid  & bus.w_ready;
    assign in_acc       = bus.in_valid & bus.in_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (w_acc) begin
                    if (LAST_BEAT == '0) begin
                        state_n = STREAM;
                        cnt_n   = '0;
                    end else begin
                        state_n = LOAD_W;
                        cnt_n   = ONE;
                    end
                end
            end
            LOAD_W: begin
                if (w_acc) begin
                    if (cnt == LAST_BEAT) begin
                        state_n = STREAM;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
            end
            STREAM: begin
                if (in_acc && bus.in_last) begin
                    state_n = DRAIN;
                    cnt_n   = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (cnt <= ONE) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Registered done lines up with the cycle in which the counter holds 1.
        done_n = (state_n == DRAIN) && (cnt_n == ONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.weight_load <= 1'b0;
            bus.weight_data <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            bus.busy        <= (state_n != IDLE);
            bus.done        <= done_n;
            bus.weight_load <= w_acc;
            if (w_acc) begin
                bus.weight_data <= bus.w_data;
            end
        end
    end

    // Row r sits behind r+1 registers, producing the diagonal wavefront.
    for (genvar r = 0; r < ARRAY_H; r++) begin : g_row
        assign row_d[r] = in_acc ? bus.in_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        sys_array_skew_line #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (r + 1)
        ) u_line (
            .clk       (clk),
            .reset_n   (reset_n),
            .in_valid  (in_acc),
            .in_data   (row_d[r]),
            .out_valid (row_v[r]),
            .out_data  (row_q[r])
        );

        assign bus.array_in[r*DATA_WIDTH +: DATA_WIDTH] = row_q[r];
    end

    assign bus.array_in_valid = row_v;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Scoreboard bench for sys_array_feeder: expectations queued at drive time, popped at output.
module tb_sys_array_feeder;

    localparam int DW    = 8;
    localparam int H     = 4;
    localparam int W     = 4;
    localparam int DRAIN = H - 1 + W;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sys_array_feeder_if #(.DATA_WIDTH(DW), .ARRAY_H(H), .ARRAY_W(W)) bus ();

    sys_array_feeder #(
        .DATA_WIDTH   (DW),
        .ARRAY_H      (H),
        .ARRAY_W      (W),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int         row;
        int         due;
        logic [7:0] data;
    } vexp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } wexp_t;

    int          total  = 0;
    int          bad    = 0;
    int          cyc    = 0;
    int          t_last = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_w = '0;
    vexp_t       expq[$];
    wexp_t       wq[$];
    int          dq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int r = 0; r < H; r++) begin
                int         f;
                logic [7:0] got;
                f = -1;
                for (int k = 0; k < expq.size(); k++) begin
                    if (expq[k].row == r && expq[k].due == cyc) f = k;
                end
                got = 8'(bus.array_in >> (r * DW));
                check($sformatf("valid_r%0d", r), 32'(1'(bus.array_in_valid >> r)), 32'(f >= 0));
                if (f >= 0) begin
                    check($sformatf("data_r%0d", r), 32'(got), 32'(expq[f].data));
                    expq.delete(f);
                end else begin
                    check($sformatf("bubble_r%0d", r), 32'(got), 32'(0));
                end
            end

            if (wq.size() > 0 && wq[0].due == cyc) begin
                check("weight_load", 32'(bus.weight_load), 32'(1));
                check("weight_data", bus.weight_data, wq[0].data);
                last_w = wq[0].data;
                void'(wq.pop_front());
            end else begin
                check("weight_load", 32'(bus.weight_load), 32'(0));
                check("weight_hold", bus.weight_data, last_w);
            end

            if (dq.size() > 0 && dq[0] == cyc) begin
                check("done", 32'(bus.done), 32'(1));
                void'(dq.pop_front());
            end else begin
                check("done", 32'(bus.done), 32'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end

    task automatic idle();
        @(negedge clk);
        bus.w_valid  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Junk activation with in_last rides alongside each beat; it must be ignored.
    task automatic send_w(input logic [31:0] d);
        @(negedge clk);
        check("w_ready", 32'(bus.w_ready), 32'(1));
        bus.w_valid  = 1'b1;
        bus.w_data   = d;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h11223344;
        bus.in_last  = 1'b1;
        wq.push_back('{due: cyc + 1, data: d});
    endtask

    task automatic send_v(input logic [31:0] d, input logic last);
        @(negedge clk);
        check("in_ready", 32'(bus.in_ready), 32'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        bus.w_valid  = 1'b1;
        bus.w_data   = 32'hDEADBEEF;
        for (int r = 0; r < H; r++) begin
            expq.push_back('{row: r, due: cyc + r + 1, data: 8'(d >> (r * DW))});
        end
        if (last) begin
            dq.push_back(cyc + DRAIN);
            t_last = cyc;
        end
    endtask

    task automatic load_weights(input logic [7:0] base);
        for (int i = 0; i < H; i++) begin
            logic [7:0] b;
            b = base + 8'(i);
            send_w({4{b}});
        end
        idle();
        check("ld_w_ready", 32'(bus.w_ready), 32'(0));
        check("ld_in_ready", 32'(bus.in_ready), 32'(1));
        check("ld_busy", 32'(bus.busy), 32'(1));
    endtask

    task automatic wait_drain();
        while (cyc < t_last + DRAIN + 1) begin
            idle();
            if (cyc == t_last + DRAIN) check("drain_busy", 32'(bus.busy), 32'(1));
        end
        check("end_busy", 32'(bus.busy), 32'(0));
        check("end_w_ready", 32'(bus.w_ready), 32'(1));
        check("end_in_ready", 32'(bus.in_ready), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wload"}, 32'(bus.weight_load), 32'(0));
        check({tag, "_wdata"}, bus.weight_data, 32'(0));
        check({tag, "_ain"}, bus.array_in, 32'(0));
        check({tag, "_ainv"}, 32'(bus.array_in_valid), 32'(0));
        check({tag, "_busy"}, 32'(bus.busy), 32'(0));
        check({tag, "_done"}, 32'(bus.done), 32'(0));
        check({tag, "_w_ready"}, 32'(bus.w_ready), 32'(1));
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(0));
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.w_valid  = 1'b1;
        bus.w_data   = 32'h01020304;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h05060708;
        bus.in_last  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        bus.w_valid  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        reset_n      = 1'b1;
        mon_en       = 1'b1;

        // weights 5..8, then single vector rows {1,2,3,4}
        load_weights(8'd5);
        send_v(32'h04030201, 1'b1);
        wait_drain();

        // bubble between A and B
        load_weights(8'h10);
        send_v(32'h01010101, 1'b0);
        idle();
        send_v(32'h05050505, 1'b1);
        wait_drain();

        // signed extremes pass through untouched
        load_weights(8'hF0);
        send_v({8'h7F, 8'h01, 8'hFF, 8'h80}, 1'b1);
        wait_drain();

        // reset during STREAM after two vectors
        load_weights(8'h21);
        send_v(32'hA1A2A3A4, 1'b0);
        send_v(32'hB1B2B3B4, 1'b0);
        idle();
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        expq.delete();
        wq.delete();
        dq.delete();
        last_w = '0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_hold_done", 32'(bus.done), 32'(0));
            check("midrst_hold_ainv", 32'(bus.array_in_valid), 32'(0));
        end
        #2;
        reset_n = 1'b1;
        #1;
        check("post_w_ready", 32'(bus.w_ready), 32'(1));
        check("post_in_ready", 32'(bus.in_ready), 32'(0));
        mon_en = 1'b1;
        repeat (4) idle();

        // recovery job after reset
        load_weights(8'h31);
        send_v(32'h0C0B0A09, 1'b1);
        wait_drain();
        repeat (2) idle();

        check("left_vec", 32'(expq.size()), 32'(0));
        check("left_w", 32'(wq.size()), 32'(0));
        check("left_done", 32'(dq.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_array_feeder.md
Name: sys_array_feeder

Overview:
Upstream feeder for the weight-stationary systolic array built from sys_array_cell instances. It runs a weight-load phase: one weight row per cycle on the array's column weight buses, with weight_load asserted. It then streams activation vectors with valid/ready handshake and applies the diagonal skew, so row r of the array receives its operand r cycles after row 0. After the last vector it drains the skew and array pipeline and pulses done.

Parameters:
DATA_WIDTH, 8, signed operand width (matches sys_array_cell)
ARRAY_H, 4, number of array rows (activation lanes, weight beats)
ARRAY_W, 4, number of array columns (weight lanes per beat)
DRAIN_CYCLES, ARRAY_H-1+ARRAY_W, cycles in DRAIN after last vector accepted

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted when w_valid&w_ready
w_data  in  ARRAY_W*DATA_WIDTH  one weight row, column c at [c*DW +: DW]
in_valid  in  1  activation vector valid
in_ready  out  1  vector accepted when in_valid&in_ready
in_data  in  ARRAY_H*DATA_WIDTH  activation vector, row r at [r*DW +: DW]
in_last  in  1  marks final vector of a job; sampled on acceptance
weight_load  out  1  to all cells' weight_load
weight_data  out  ARRAY_W*DATA_WIDTH  to top-row weight_data inputs
array_in  out  ARRAY_H*DATA_WIDTH  skewed operands to column-0 input_data, row r
array_in_valid  out  ARRAY_H  per-row operand valid
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of DRAIN

Behaviour:
- Reset, asynchronous: state=IDLE, counters=0, all skew registers=0. Every output is 0 except w_ready, which is 1.
- All outputs are registered except w_ready and in_ready, which decode from state.
- FSM: IDLE, LOAD_W, STREAM, DRAIN.
- IDLE: w_ready=1, in_ready=0. An accepted weight beat goes to LOAD_W with beat count 1.
- LOAD_W: w_ready=1. Each accepted beat increments the count. When the ARRAY_H-th beat is accepted, go to STREAM.
- Weight output timing: for each accepted beat, weight_data=w_data and weight_load=1 in the following cycle. Otherwise weight_load=0 and weight_data holds its last value.
- Weight ordering: the first beat ends up in row ARRAY_H-1 because the array shifts weights down. The caller supplies rows bottom-first.
- STREAM: in_ready=1, w_ready=0. Weight beats are ignored.
- Skew: an accepted vector places row r on array_in[r] with array_in_valid[r]=1, exactly r+1 cycles after acceptance.
- Bubbles: in a cycle with no acceptance, a 0 operand with valid=0 enters the skew line. Empty diagonal slots output 0 with valid=0.
- Skew storage: row r uses an (r+1)-deep register chain carrying {valid, data}. Data passes bit-exact, signed, with no arithmetic.
- Accepting a vector with in_last=1 moves to DRAIN and loads a counter with DRAIN_CYCLES. in_ready=0 from the next cycle.
- DRAIN: the skew line keeps shifting with zero/invalid inserts. The counter decrements each cycle. done=1 in the cycle the counter goes 1->0, then the FSM returns to IDLE.
- Weights persist across jobs. A new job always starts with a full ARRAY_H-beat weight load.
- in_valid outside STREAM: not accepted; no effect.
- w_valid and in_valid high together: only the one matching the current state is accepted.
- Reset mid-operation: immediate return to reset values. No done pulse. Partial skew contents are discarded.

Decomposition:
- Package sys_array_pkg:
  - typedef state_t {IDLE, LOAD_W, STREAM, DRAIN}
  - function clog2-based counter width for max(ARRAY_H, DRAIN_CYCLES)
  - localparam DATA_WIDTH default shared with sys_array_cell
- Sub-module sys_array_skew_line (parameters DATA_WIDTH, DEPTH): one row's {valid, data} shift chain, async reset to 0. The feeder instantiates it ARRAY_H times via generate, with DEPTH=r+1.

Test Plan:
- Reset check (ARRAY_H=ARRAY_W=4, DW=8). Hold reset_n=0 for 4 clocks, with in_valid=1 and w_valid=1. Required: weight_load=0, array_in=0, array_in_valid=0, busy=0, done=0, w_ready=1, in_ready=0.
- Weight load. Send 4 beats {5,5,5,5}, {6,...}, {7,...}, {8,...} back-to-back. Required: weight_load=1 for exactly 4 cycles, each one cycle after its accept; weight_data is 5,6,7,8 in order. w_ready=0 and in_ready=1 from the cycle after the 4th accept.
- Skew, single vector. Send in_data rows {1,2,3,4} with in_last=1 at cycle T. Required:
  - array_in[0]=1 valid at T+1; [1]=2 at T+2; [2]=3 at T+3; [3]=4 at T+4; all other slots 0/invalid.
  - done=1 only at T+7; busy=0 at T+8.
- Bubble. Send vector A={1,1,1,1}, idle one cycle, then B={5,5,5,5} with in_last. Required: row r shows 1 at A+r+1, 0/invalid at A+r+2, and 5 at A+r+3.
- Signed pass-through. Send row0=-128 (8'h80) and row3=127. Required: array_in[0]=8'h80 and array_in[3]=8'h7F, unmodified.
- Reset mid-operation. Drop reset_n during STREAM after 2 accepted vectors. Required:
  - outputs return to reset values immediately, and done never pulses;
  - after release, w_ready=1 and in_ready=0.
